// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: master FSM states, mode encoding
// and the default acknowledge timeout.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_WAIT_ACK,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } mst_state_e;

  localparam int ACK_TIMEOUT_DEF = 15;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_shift_reg.sv
// LSB-first shift register with parallel load and a count of bits shifted
// since the last load.
module bus_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_data;
      cnt <= '0;
    end else if (shift_en) begin
      q   <= {sin, q[WIDTH-1:1]};
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Initiator port of the serial bus: one parallel transaction in, serial
// address/data on the shared bus, one-cycle response out.
// Optional even-parity bits are enabled with `define BUS_MASTER_PARITY_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  txn_valid_i,
  output logic                  txn_ready_o,
  input  logic                  txn_write_i,
  input  logic [ADDR_WIDTH-1:0] txn_addr_i,
  input  logic [DATA_WIDTH-1:0] txn_wdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  bus_req_o,
  input  logic                  bus_grant_i,
  output logic                  bus_mode_o,
  output logic                  bus_mvalid_o,
  output logic                  bus_mout_o,
  input  logic                  bus_ack_i,
  input  logic                  bus_svalid_i,
  input  logic                  bus_sin_i
);

  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int ACNT_W = $clog2(ADDR_WIDTH + 2);
  localparam int DCNT_W = $clog2(DATA_WIDTH + 2);
`ifdef BUS_MASTER_PARITY_EN
  localparam int PAR_BITS = 1;
  localparam logic [ACNT_W-1:0] ADDR_FULL = ACNT_W'(ADDR_WIDTH);
  localparam logic [DCNT_W-1:0] DATA_FULL = DCNT_W'(DATA_WIDTH);
`else
  localparam int PAR_BITS = 0;
`endif
  localparam logic [ACNT_W-1:0] ADDR_LAST = ACNT_W'(ADDR_WIDTH - 1 + PAR_BITS);
  localparam logic [DCNT_W-1:0] DATA_LAST = DCNT_W'(DATA_WIDTH - 1 + PAR_BITS);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

  mst_state_e state_q, state_d;
  logic              write_q;
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              accept, addr_shift, data_shift, data_sin;
  logic              addr_bit, data_bit;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ACNT_W-1:0]     addr_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DCNT_W-1:0]     data_cnt;

  // Outgoing words rotate so the original value (and its parity) survives the shift.
  bus_shift_reg #(.WIDTH(ADDR_WIDTH), .CNT_W(ACNT_W)) u_addr_sr (
    .clk(clk), .rst(rst), .load(accept), .load_data(txn_addr_i),
    .shift_en(addr_shift), .sin(addr_q[0]), .q(addr_q), .cnt(addr_cnt)
  );

  bus_shift_reg #(.WIDTH(DATA_WIDTH), .CNT_W(DCNT_W)) u_data_sr (
    .clk(clk), .rst(rst), .load(accept), .load_data(txn_wdata_i),
    .shift_en(data_shift), .sin(data_sin), .q(data_q), .cnt(data_cnt)
  );

`ifdef BUS_MASTER_PARITY_EN
  assign addr_bit = (addr_cnt == ADDR_FULL) ? ^addr_q : addr_q[0];
  assign data_bit = (data_cnt == DATA_FULL) ? ^data_q : data_q[0];
`else
  logic addr_hi_unused;
  assign addr_hi_unused = ^addr_q[ADDR_WIDTH-1:1];
  assign addr_bit = addr_q[0];
  assign data_bit = data_q[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      write_q  <= MODE_READ;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
      if (accept) write_q <= txn_write_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    to_cnt_d     = '0;
    accept       = 1'b0;
    addr_shift   = 1'b0;
    data_shift   = 1'b0;
    data_sin     = data_q[0];
    txn_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_err_o    = 1'b0;
    rsp_rdata_o  = '0;
    bus_req_o    = 1'b0;
    bus_mode_o   = MODE_READ;
    bus_mvalid_o = 1'b0;
    bus_mout_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txn_ready_o = 1'b1;
        if (txn_valid_i) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req_o = 1'b1;
        if (bus_grant_i) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        bus_req_o  = 1'b1;
        bus_mode_o = write_q;
        if (!bus_grant_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          bus_mvalid_o = 1'b1;
          bus_mout_o   = addr_bit;
          addr_shift   = 1'b1;
          if (addr_cnt == ADDR_LAST) state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        bus_req_o  = 1'b1;
        bus_mode_o = write_q;
        if (!bus_grant_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (bus_ack_i) begin
          state_d = (write_q == MODE_WRITE) ? ST_WDATA : ST_RDATA;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_WDATA: begin
        bus_req_o  = 1'b1;
        bus_mode_o = write_q;
        if (!bus_grant_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          bus_mvalid_o = 1'b1;
          bus_mout_o   = data_bit;
          data_shift   = 1'b1;
          if (data_cnt == DATA_LAST) state_d = ST_DONE;
        end
      end
      ST_RDATA: begin
        bus_req_o  = 1'b1;
        bus_mode_o = write_q;
        data_sin   = bus_sin_i;
        if (!bus_grant_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (bus_svalid_i) begin
`ifdef BUS_MASTER_PARITY_EN
          if (data_cnt == DATA_FULL) begin
            if (bus_sin_i != ^data_q) err_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            data_shift = 1'b1;
          end
`else
          data_shift = 1'b1;
          if (data_cnt == DATA_LAST) state_d = ST_DONE;
`endif
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_DONE: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (err_q || write_q == MODE_WRITE) ? '0 : data_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Initiator-side port of the serial bus.
- Accepts one parallel read/write transaction from a local initiator and raises a bus request toward the arbiter.
- Once granted, serialises the address and write data onto the shared bus, or deserialises read data from it.
- Returns a one-cycle response and releases the request; one instance per initiator, driving req_i_1/req_i_2 and consuming grant_i_1/grant_i_2.

Parameters:
ADDR_WIDTH, 16, address bits shifted per transaction
DATA_WIDTH, 8, data bits shifted per transaction
ACK_TIMEOUT, 15, max cycles waited for target ack or read bit before error (counter width $clog2(ACK_TIMEOUT+1))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
txn_valid_i  in  1  initiator presents transaction
txn_ready_o  out  1  port can accept transaction
txn_write_i  in  1  1=write, 0=read
txn_addr_i  in  ADDR_WIDTH  target address
txn_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_err_o  out  1  completion failed (timeout/grant loss), valid with rsp_valid_o
rsp_rdata_o  out  DATA_WIDTH  read data, valid with rsp_valid_o on successful read
bus_req_o  out  1  request to arbiter
bus_grant_i  in  1  grant from arbiter
bus_mode_o  out  1  1=write, held for whole granted tenure
bus_mvalid_o  out  1  serial bit valid from master
bus_mout_o  out  1  serial bit from master
bus_ack_i  in  1  target ack after address
bus_svalid_i  in  1  serial bit valid from target
bus_sin_i  in  1  serial bit from target

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - FSM IDLE.
  - All outputs 0 except txn_ready_o=1.
  - Shift registers and counters cleared.
  - Reset mid-transfer drops bus_req_o the next edge; no response is issued.
- States: IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, DONE.
- IDLE:
  - txn_ready_o=1.
  - On txn_valid_i, latch write/addr/wdata, go to REQ.
- REQ:
  - bus_req_o=1.
  - On bus_grant_i=1, go to ADDR next cycle.
  - Waits indefinitely; no timeout on grant.
- ADDR:
  - bus_req_o=1, bus_mvalid_o=1.
  - Address shifted LSB first, one bit per cycle, ADDR_WIDTH cycles.
  - Then WAIT_ACK.
- WAIT_ACK:
  - Timeout counter increments per cycle.
  - bus_ack_i=1: go to WDATA (write) or RDATA (read); counter cleared.
  - Counter reaches ACK_TIMEOUT: go to DONE with error.
- WDATA:
  - bus_mvalid_o=1.
  - wdata shifted LSB first, DATA_WIDTH cycles, then DONE.
- RDATA:
  - On each bus_svalid_i cycle, shift bus_sin_i in LSB first and clear the timeout counter.
  - After DATA_WIDTH bits, go to DONE.
  - ACK_TIMEOUT idle cycles between bits: go to DONE with error.
- Grant loss: bus_grant_i=0 in any of ADDR/WAIT_ACK/WDATA/RDATA goes to DONE with error the next cycle; bus_mvalid_o is forced 0 that same cycle.
- DONE:
  - bus_req_o=0.
  - rsp_valid_o=1 for exactly one cycle, with rsp_err_o and rsp_rdata_o (rdata=0 on error or write).
  - Then IDLE.
- Latency for an uncontended write = 1 (REQ) + 1 (arbiter grant) + ADDR_WIDTH + ack wait + DATA_WIDTH + 1 (DONE).
- txn_ready_o is 0 in all non-IDLE states; a transaction accepted in the DONE cycle is not possible.
- bus_mout_o is 0 whenever bus_mvalid_o=0.

Optional Feature:
- Macro: BUS_MASTER_PARITY_EN.
- Defined:
  - One extra even-parity bit driven with bus_mvalid_o after the last address bit and after the last write data bit.
  - For reads, one extra received bit after DATA_WIDTH bits is checked; a mismatch sets rsp_err_o in DONE.
- Undefined: no parity bits; bit counts exactly ADDR_WIDTH/DATA_WIDTH.

Decomposition:
- Shared package bus_pkg holds:
  - the master FSM state enum (3-bit);
  - the ACK_TIMEOUT default;
  - the mode encoding constants (MODE_READ=0, MODE_WRITE=1).
- One natural sub-module: bus_shift_reg, a parameterised width LSB-first shift register with load, shift-out, shift-in and bit counter.
- bus_shift_reg is instantiated once for address and once for data.

Test Plan:
- Write addr=0x00A5, wdata=0x3C, grant 1 cycle after req, ack 2 cycles after address:
  - bus_mout_o bits 1,0,1,0,0,1,0,1,0… then 0,0,1,1,1,1,0,0;
  - rsp_valid_o=1, rsp_err_o=0;
  - bus_req_o low in the DONE cycle.
- Read addr=0x0010, target returns 0x96 with one-cycle gaps between bits -> rsp_rdata_o=0x96, rsp_err_o=0.
- Write with bus_ack_i never asserted -> after exactly 15 WAIT_ACK cycles, rsp_valid_o=1, rsp_err_o=1, no data bits driven.
- Grant held low for 20 cycles after request:
  - bus_req_o stays 1, txn_ready_o=0, no timeout;
  - transfer proceeds normally after grant.
- Grant dropped during the 5th address bit -> bus_mvalid_o=0 the next cycle, rsp_err_o=1, return to IDLE, txn_ready_o=1.
- rst asserted mid-WDATA -> next edge all outputs 0, txn_ready_o=1, no rsp_valid_o pulse.
